exe_stage: RTL

//   Execute stage of the 5-stage LoongArch pipeline, directly downstream of decode.
//   - Captures the decode-to-execute bus through a valid/allow_in pipeline register.
//   - Computes the ALU result and issues the data-SRAM request for ld.w / st.w.
//   - Hands {load flag, write-enable, dest, pc, result} to the memory stage.

---
 rtl/exe_stage_pkg.sv | 43 ++++
 rtl/exe_stage_alu.sv | 45 ++++
 rtl/exe_stage.sv | 72 +++++++
 3 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU opcode bit indices
// and the packed layouts of the decode->execute and execute->memory buses.
package exe_stage_pkg;

    localparam int DS_TO_ES_WD = 148;
    localparam int ES_TO_MS_WD = 71;
    localparam int ES_FWD_WD   = 39;
    localparam int ALU_OP_WD   = 12;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;

    typedef struct packed {
        logic                 rf_or_mem;
        logic                 mem_we;
        logic                 rf_we;
        logic [4:0]           dest;
        logic [ALU_OP_WD-1:0] alu_op;
        logic [31:0]          pc;
        logic [31:0]          rkd_value;
        logic [31:0]          alu_src1;
        logic [31:0]          alu_src2;
    } ds_to_es_bus_t;

    typedef struct packed {
        logic        rf_or_mem;
        logic        rf_we;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] alu_result;
    } es_to_ms_bus_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational 32-bit ALU with a one-hot opcode; an all-zero opcode yields 0.
module exe_stage_alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_WD-1:0] alu_op,
    input  logic [31:0]          alu_src1,
    input  logic [31:0]          alu_src2,
    output logic [31:0]          alu_result
);

    logic [4:0]  sa;
    logic [31:0] add_res, sub_res, slt_res, sltu_res;
    logic [31:0] and_res, nor_res, or_res, xor_res;
    logic [31:0] sll_res, srl_res, sra_res;

    always_comb begin
        sa       = alu_src2[4:0];
        add_res  = alu_src1 + alu_src2;
        sub_res  = alu_src1 - alu_src2;
        slt_res  = {31'b0, ($signed(alu_src1) < $signed(alu_src2))};
        sltu_res = {31'b0, (alu_src1 < alu_src2)};
        and_res  = alu_src1 & alu_src2;
        nor_res  = ~(alu_src1 | alu_src2);
        or_res   = alu_src1 | alu_src2;
        xor_res  = alu_src1 ^ alu_src2;
        sll_res  = alu_src1 << sa;
        srl_res  = alu_src1 >> sa;
        sra_res  = $unsigned($signed(alu_src1) >>> sa);
    end

    // AND-OR mux: each opcode bit gates exactly one result onto the output.
    assign alu_result = ({32{alu_op[OP_ADD]}}  & add_res)
                      | ({32{alu_op[OP_SUB]}}  & sub_res)
                      | ({32{alu_op[OP_SLT]}}  & slt_res)
                      | ({32{alu_op[OP_SLTU]}} & sltu_res)
                      | ({32{alu_op[OP_AND]}}  & and_res)
                      | ({32{alu_op[OP_NOR]}}  & nor_res)
                      | ({32{alu_op[OP_OR]}}   & or_res)
                      | ({32{alu_op[OP_XOR]}}  & xor_res)
                      | ({32{alu_op[OP_SLL]}}  & sll_res)
                      | ({32{alu_op[OP_SRL]}}  & srl_res)
                      | ({32{alu_op[OP_SRA]}}  & sra_res)
                      | ({32{alu_op[OP_LUI]}}  & alu_src2);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: pipeline register, ALU and data-SRAM request for ld.w/st.w.
// Optional macro EXE_FWD_EN adds es_fwd_bus for decode-side forwarding.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ds_to_es_valid,
    input  logic [DS_TO_ES_WD-1:0] ds_to_es_bus,
    input  logic                   ms_allow_in,
    output logic                   es_allow_in,
    output logic                   es_to_ms_valid,
    output logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
    output logic                   data_sram_en,
    output logic [3:0]             data_sram_we,
    output logic [31:0]            data_sram_addr,
    output logic [31:0]            data_sram_wdata
`ifdef EXE_FWD_EN
    ,
    output logic [ES_FWD_WD-1:0]   es_fwd_bus
`endif
);

    // Handshake: an instruction moves across a boundary on a clock edge exactly
    // when the upstream valid and the downstream allow_in are both high.
    logic          es_valid;
    logic          es_ready_go;
    logic          es_handoff;
    ds_to_es_bus_t es_bus_r;
    logic [31:0]   alu_result;

    assign es_ready_go    = 1'b1;
    assign es_allow_in    = !es_valid || (es_ready_go && ms_allow_in);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign es_handoff     = es_valid && ms_allow_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            es_valid <= 1'b0;
            es_bus_r <= '0;
        end else begin
            if (es_allow_in) begin
                es_valid <= ds_to_es_valid;
            end
            if (ds_to_es_valid && es_allow_in) begin
                es_bus_r <= ds_to_es_bus;
            end
        end
    end

    exe_stage_alu u_alu (
        .alu_op     (es_bus_r.alu_op),
        .alu_src1   (es_bus_r.alu_src1),
        .alu_src2   (es_bus_r.alu_src2),
        .alu_result (alu_result)
    );

    assign es_to_ms_bus = {es_bus_r.rf_or_mem, es_bus_r.rf_we, es_bus_r.dest,
                           es_bus_r.pc, alu_result};

    // Request only on the handoff cycle so read data lines up with the memory stage.
    assign data_sram_en    = es_handoff && (es_bus_r.rf_or_mem || es_bus_r.mem_we);
    assign data_sram_we    = {4{es_handoff && es_bus_r.mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = es_bus_r.rkd_value;

`ifdef EXE_FWD_EN
    assign es_fwd_bus = {es_valid && es_bus_r.rf_we, es_bus_r.rf_or_mem,
                         es_bus_r.dest, alu_result};
`endif

endmodule
